imem_loader: RTL

- Writer side of the instruction-fetch path: streams a program into instruction memory word-by-word, which the PC/fetch logic later reads.
- Accepts bytes over a valid/ready handshake and assembles them big-endian into 32-bit words.
- Writes each word to consecutive word addresses starting at 0.
- Holds the CPU (PC) in reset until the load completes.

---
 rtl/imem_loader.sv | 114 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a byte program into instruction memory as
// big-endian 32-bit words and holds the CPU in reset until the load is done.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_reset_n
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, next_state;

    logic [1:0]          byte_cnt;
    logic [ADDR_WIDTH:0] word_cnt;
    logic [ADDR_WIDTH:0] target;
    logic [23:0]         shift;

    logic take;
    logic go;
    logic last_byte;
    logic last_word;

    assign take      = byte_valid && byte_ready;
    assign go        = start && (state == IDLE || state == DONE);
    assign last_byte = take && (byte_cnt == 2'd3);
    assign last_word = (word_cnt + 1'b1) == target;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) next_state = (num_words == '0) ? DONE : RECV;
            end
            RECV: begin
                if (last_byte) next_state = WRITE;
            end
            WRITE: begin
                next_state = last_word ? DONE : RECV;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == RECV);
    end

    // Status outputs are registered copies of the state being entered,
    // so they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cpu_reset_n <= 1'b0;
            byte_cnt    <= '0;
            word_cnt    <= '0;
            target      <= '0;
            shift       <= '0;
        end else begin
            mem_we      <= (next_state == WRITE);
            busy        <= (next_state == RECV) || (next_state == WRITE);
            done        <= (next_state == DONE);
            cpu_reset_n <= (next_state == DONE);

            if (go && num_words != '0) begin
                target   <= (num_words > DEPTH_W) ? DEPTH_W : num_words;
                word_cnt <= '0;
                byte_cnt <= '0;
                mem_addr <= '0;
            end

            if (take) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= {shift[15:0], byte_data};
                if (byte_cnt == 2'd3) mem_wdata <= {shift, byte_data};
            end

            // Final word keeps its address; no wrap past DEPTH-1.
            if (state == WRITE) begin
                word_cnt <= word_cnt + 1'b1;
                if (!last_word) mem_addr <= mem_addr + 1'b1;
            end
        end
    end

endmodule
